// File: rtl/atomic_rmw_pkg.sv
// Shared types for the atomic RMW engine: opcode enum, stage record,
// and the pure new-value/success function used in the compute stage.
package atomic_rmw_pkg;

    // Record field widths; engine parameters must not exceed these.
    localparam int P_AW = 8;
    localparam int P_DW = 32;
    localparam int P_IW = 4;
    localparam int P_PW = 2;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_CAS  = 3'd2,
        OP_EXCH = 3'd3,
        OP_UMIN = 3'd4,
        OP_UMAX = 3'd5,
        OP_AND  = 3'd6,
        OP_OR   = 3'd7
    } op_e;

    typedef struct packed {
        logic            valid;
        logic [P_AW-1:0] addr;
        op_e             op;
        logic [P_DW-1:0] data;
        logic [P_DW-1:0] cmp;
        logic [P_PW-1:0] port;
        logic [P_IW-1:0] id;
    } stage_t;

    typedef struct packed {
        logic [P_DW-1:0] value;
        logic            success;
    } rmw_res_t;

    function automatic rmw_res_t rmw_compute(
        input op_e             op,
        input logic [P_DW-1:0] old,
        input logic [P_DW-1:0] data,
        input logic [P_DW-1:0] cmp
    );
        rmw_res_t r;
        r.value   = old;
        r.success = 1'b1;
        case (op)
            OP_LOAD: r.value = old;
            OP_ADD:  r.value = old + data;
            OP_CAS: begin
                r.success = (old == cmp);
                r.value   = r.success ? data : old;
            end
            OP_EXCH: r.value = data;
            OP_UMIN: r.value = (old < data) ? old : data;
            OP_UMAX: r.value = (old > data) ? old : data;
            OP_AND:  r.value = old & data;
            OP_OR:   r.value = old | data;
            default: r.value = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/atomic_rmw_engine_rr_arbiter.sv
// Round-robin arbiter: grants the first valid port at or after the
// pointer. Ports: i_valid, i_enable (advance pointer), o_grant, o_idx.
module rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         i_valid,
    input  logic                         i_enable,
    output logic [NUM_PORTS-1:0]         o_grant,
    output logic [$clog2(NUM_PORTS)-1:0] o_idx
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_j;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_j = PW'((32'(r_ptr) + 32'(k)) % 32'(NUM_PORTS));
            if (!w_found && i_valid[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_enable && w_found) begin
            if (32'(o_idx) == 32'(NUM_PORTS - 1))
                r_ptr <= '0;
            else
                r_ptr <= o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/atomic_rmw_engine.sv
// Multi-port pipelined atomic RMW engine over a word scratch memory.
// Ports: per-port req_* (flattened), resp_* with valid/ready.
module atomic_rmw_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEMWORDS   = 256,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*3-1:0]          req_op,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_cmp,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]   req_id,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            resp_success,
    output logic [$clog2(NUM_PORTS)-1:0]    resp_port,
    output logic [ID_WIDTH-1:0]             resp_id
);
    import atomic_rmw_pkg::*;

    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]  w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_adv;
    stage_t                w_req;
    stage_t                r_s1;
    stage_t                r_s2;
    logic [DATA_WIDTH-1:0] r_mem [MEMWORDS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_val;
    logic [P_DW-1:0]       w_old;
    rmw_res_t              w_res;
    logic [DATA_WIDTH-1:0] w_new;
    logic                  w_s1_inr;
    logic                  w_s2_inr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_success;
    logic [PW-1:0]         r_resp_port;
    logic [ID_WIDTH-1:0]   r_resp_id;

    // Whole pipeline moves only when the response slot can take a beat.
    assign w_adv = !r_resp_valid || resp_ready;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (req_valid),
        .i_enable (w_adv),
        .o_grant  (w_grant),
        .o_idx    (w_gidx)
    );

    assign req_ready = (w_adv && !rst) ? w_grant : '0;

    always_comb begin
        w_req       = '0;
        w_req.valid = |w_grant;
        w_req.addr  = P_AW'(req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH]);
        w_req.op    = op_e'(req_op[w_gidx*3 +: 3]);
        w_req.data  = P_DW'(req_data[w_gidx*DATA_WIDTH +: DATA_WIDTH]);
        w_req.cmp   = P_DW'(req_cmp[w_gidx*DATA_WIDTH +: DATA_WIDTH]);
        w_req.port  = P_PW'(w_gidx);
        w_req.id    = P_IW'(req_id[w_gidx*ID_WIDTH +: ID_WIDTH]);
    end

    assign w_s1_inr = 32'(r_s1.addr) < 32'(MEMWORDS);
    assign w_s2_inr = 32'(r_s2.addr) < 32'(MEMWORDS);
    assign w_rd_idx = w_s1_inr ? r_s1.addr[ADDR_WIDTH-1:0] : '0;
    assign w_wr_idx = r_s2.addr[ADDR_WIDTH-1:0];

    // Read and write share an edge, so the read misses the write
    // leaving S2; r_fwd substitutes that value one cycle later.
    assign w_old = r_fwd ? P_DW'(r_fwd_val) : P_DW'(r_rdata);
    assign w_res = rmw_compute(r_s2.op, w_old, r_s2.data, r_s2.cmp);
    assign w_new = w_res.value[DATA_WIDTH-1:0];
    assign w_we  = r_s2.valid && w_s2_inr;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (w_we)
                r_mem[w_wr_idx] <= w_new;
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1           <= '0;
            r_s2           <= '0;
            r_fwd          <= 1'b0;
            r_fwd_val      <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_resp_success <= 1'b0;
            r_resp_port    <= '0;
            r_resp_id      <= '0;
        end else if (w_adv) begin
            r_s1         <= w_req;
            r_s2         <= r_s1;
            r_fwd        <= w_we && r_s1.valid
                            && (r_s1.addr == r_s2.addr);
            r_fwd_val    <= w_new;
            r_resp_valid <= r_s2.valid;
            if (r_s2.valid) begin
                r_resp_data    <= w_s2_inr ? w_old[DATA_WIDTH-1:0] : '0;
                r_resp_success <= w_s2_inr && w_res.success;
                r_resp_port    <= r_s2.port[PW-1:0];
                r_resp_id      <= r_s2.id[ID_WIDTH-1:0];
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_success = r_resp_success;
    assign resp_port    = r_resp_port;
    assign resp_id      = r_resp_id;

endmodule

// File: tb/tb_atomic_rmw_engine.sv
// Bench for atomic_rmw_engine: queue-based linearised model plus
// directed literal checks and randomized multi-port traffic.
module tb_atomic_rmw_engine;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 200;
    localparam int NP = 4;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*3-1:0]   req_op = '0;
    logic [NP*DW-1:0]  req_data = '0;
    logic [NP*DW-1:0]  req_cmp = '0;
    logic [NP*IW-1:0]  req_id = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DW-1:0]     resp_data;
    logic              resp_success;
    logic [1:0]        resp_port;
    logic [IW-1:0]     resp_id;

    atomic_rmw_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMWORDS(MW),
        .NUM_PORTS(NP), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op),
        .req_data(req_data), .req_cmp(req_cmp), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_success(resp_success),
        .resp_port(resp_port), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        bit          inr;
        logic [31:0] old;
        bit          known;
        bit          succ;
        int          port;
        int          id;
        int          age;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        succ;
        int          port;
        int          id;
    } got_t;

    exp_t        q[$];
    got_t        log_q[$];
    logic [31:0] mm [256];
    bit          kn [256];
    int          p = 0;
    int          total = 0;
    int          bad = 0;
    bit          in_rst = 0;

    bit          m_rv, m_adv;
    int          m_g, m_a, m_op;
    logic [NP-1:0] m_er;
    logic [31:0] m_d, m_c, m_o, m_n;
    exp_t        m_e;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Model: every op takes effect at its accept edge, in accept order.
    // Responses appear after two advancing edges and leave on handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (!in_rst) begin
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].age < 2 && q[i].inr) begin
                        mm[q[i].addr] = q[i].old;
                        kn[q[i].addr] = q[i].known;
                    end
                q.delete();
                p = 0;
            end
            in_rst = 1;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        end else begin
            in_rst = 0;
            m_rv  = (q.size() > 0) && (q[0].age >= 2);
            m_adv = !m_rv || resp_ready;
            m_g   = -1;
            for (int k = 0; k < NP; k++)
                if (m_g < 0 && req_valid[(p + k) % NP])
                    m_g = (p + k) % NP;
            m_er = '0;
            if (m_adv && m_g >= 0)
                m_er[m_g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(m_er));
            chk("resp_valid", 64'(resp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("resp_port", 64'(resp_port), 64'(q[0].port));
                chk("resp_id", 64'(resp_id), 64'(q[0].id));
                if (q[0].known) begin
                    chk("resp_data", 64'(resp_data), 64'(q[0].old));
                    chk("resp_success", 64'(resp_success),
                        64'(q[0].succ));
                end
            end
            if (m_rv && resp_ready) begin
                log_q.push_back('{resp_data, resp_success,
                                  int'(resp_port), int'(resp_id)});
                void'(q.pop_front());
            end
            if (m_adv)
                foreach (q[i]) q[i].age++;
            if (m_adv && m_g >= 0) begin
                m_a  = int'(req_addr[m_g*AW +: AW]);
                m_op = int'(req_op[m_g*3 +: 3]);
                m_d  = req_data[m_g*DW +: DW];
                m_c  = req_cmp[m_g*DW +: DW];
                m_e.addr = m_a;
                m_e.inr  = (m_a < MW);
                m_e.port = m_g;
                m_e.id   = int'(req_id[m_g*IW +: IW]);
                m_e.age  = 0;
                if (m_e.inr) begin
                    m_o = mm[m_a];
                    m_e.old   = m_o;
                    m_e.known = kn[m_a];
                    case (m_op)
                        0: m_n = m_o;
                        1: m_n = m_o + m_d;
                        2: m_n = (m_o == m_c) ? m_d : m_o;
                        3: m_n = m_d;
                        4: m_n = (m_o < m_d) ? m_o : m_d;
                        5: m_n = (m_o > m_d) ? m_o : m_d;
                        6: m_n = m_o & m_d;
                        default: m_n = m_o | m_d;
                    endcase
                    m_e.succ = (m_op == 2) ? (m_o == m_c) : 1'b1;
                    mm[m_a] = m_n;
                    kn[m_a] = kn[m_a] || (m_op == 3);
                end else begin
                    m_e.old   = '0;
                    m_e.known = 1;
                    m_e.succ  = 0;
                end
                q.push_back(m_e);
                p = (m_g + 1) % NP;
            end
        end
    end

    task automatic set_req(input int pt, input int op, input int a,
                           input logic [31:0] d, input logic [31:0] c,
                           input int id);
        req_valid[pt] = 1'b1;
        req_addr[pt*AW +: AW] = AW'(a);
        req_op[pt*3 +: 3] = 3'(op);
        req_data[pt*DW +: DW] = d;
        req_cmp[pt*DW +: DW] = c;
        req_id[pt*IW +: IW] = IW'(id);
    endtask

    task automatic send(input int pt, input int op, input int a,
                        input logic [31:0] d, input logic [31:0] c,
                        input int id);
        int n = 0;
        req_valid = '0;
        set_req(pt, op, a, d, c, id);
        while (n < 100) begin
            @(negedge clk);
            if (req_ready[pt]) break;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout port=%0d actual=none required=accept",
                     pt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        resp_ready = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
    endtask

    task automatic chk_log(input string nm, input int idx,
                           input logic [31:0] d, input logic s);
        if (idx >= log_q.size()) begin
            chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
        end else begin
            chk({nm, "_data"}, 64'(log_q[idx].data), 64'(d));
            chk({nm, "_succ"}, 64'(log_q[idx].succ), 64'(s));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, op, n, mx, mn, maxdiff, cyc;
        int cnt [NP];
        logic [31:0] d, c;

        #2 rst = 1'b1;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        chk("reset_resp_success", 64'(resp_success), 64'd0);
        chk("reset_resp_port", 64'(resp_port), 64'd0);
        chk("reset_resp_id", 64'(resp_id), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // EXCH then ADD back to back, then LOAD
        log_q.delete();
        send(0, 3, 5, 32'd10, 32'd0, 1);
        send(0, 1, 5, 32'd3, 32'd0, 2);
        send(0, 0, 5, 32'd0, 32'd0, 3);
        idle();
        drain();
        chk_log("add_old", 1, 32'd10, 1'b1);
        chk_log("add_load", 2, 32'd13, 1'b1);

        // response latency with an idle pipeline
        send(1, 0, 5, 32'd0, 32'd0, 4);
        idle();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 10);
        chk("latency", 64'(n), 64'd2);
        drain();

        // CAS success then failure
        log_q.delete();
        send(0, 3, 7, 32'd4, 32'd0, 0);
        send(0, 2, 7, 32'd9, 32'd4, 1);
        send(0, 2, 7, 32'd1, 32'd4, 2);
        send(0, 0, 7, 32'd0, 32'd0, 3);
        idle();
        drain();
        chk_log("cas_ok", 1, 32'd4, 1'b1);
        chk_log("cas_fail", 2, 32'd9, 1'b0);
        chk_log("cas_load", 3, 32'd9, 1'b1);

        // forwarding chain on one word
        log_q.delete();
        send(2, 3, 12, 32'd3, 32'd0, 0);
        send(2, 5, 12, 32'd20, 32'd0, 1);
        send(2, 4, 12, 32'd15, 32'd0, 2);
        send(2, 7, 12, 32'h100, 32'd0, 3);
        send(2, 0, 12, 32'd0, 32'd0, 4);
        idle();
        drain();
        chk_log("fwd_umax", 1, 32'd3, 1'b1);
        chk_log("fwd_umin", 2, 32'd20, 1'b1);
        chk_log("fwd_or", 3, 32'd15, 1'b1);
        chk_log("fwd_load", 4, 32'h10F, 1'b1);

        // out-of-range address
        log_q.delete();
        send(3, 1, 210, 32'd5, 32'd0, 9);
        idle();
        drain();
        chk_log("oor", 0, 32'd0, 1'b0);

        // four ports, 100 ADD +1 each, to one word
        send(0, 3, 0, 32'd0, 32'd0, 0);
        idle();
        drain();
        log_q.delete();
        foreach (cnt[i]) cnt[i] = 0;
        maxdiff = 0;
        cyc = 0;
        while ((cnt[0] < 100 || cnt[1] < 100 || cnt[2] < 100
                || cnt[3] < 100) && cyc < 2000) begin
            req_valid = '0;
            for (int i = 0; i < NP; i++)
                if (cnt[i] < 100) set_req(i, 1, 0, 32'd1, 32'd0, i);
            @(negedge clk);
            for (int i = 0; i < NP; i++)
                if (req_ready[i]) cnt[i]++;
            mx = cnt[0];
            mn = cnt[0];
            for (int i = 1; i < NP; i++) begin
                if (cnt[i] > mx) mx = cnt[i];
                if (cnt[i] < mn) mn = cnt[i];
            end
            if (mx - mn > maxdiff) maxdiff = mx - mn;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("contend_done", 64'(cyc < 2000), 64'd1);
        chk("contend_fair", 64'(maxdiff <= 1), 64'd1);
        send(1, 0, 0, 32'd0, 32'd0, 5);
        idle();
        drain();
        chk_log("contend_total", log_q.size() - 1, 32'd400, 1'b1);

        // backpressure mid-stream
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i % NP, 1, 3, 32'd1, 32'd0, i);
                req_valid = '0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 resp_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 resp_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("bp_count", 64'(log_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk("bp_order", 64'(log_q[i].id), 64'(i));

        // seed a small address range, then random traffic
        for (int i = 0; i < 16; i++)
            send(i % NP, 3, i, 32'(i * 7), 32'd0, i);
        idle();
        drain();
        repeat (3000) begin
            req_valid = '0;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 9) == 0)
                        a = 200 + int'($urandom_range(0, 55));
                    else
                        a = int'($urandom_range(0, 7));
                    op = int'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0)
                        d = $urandom;
                    else
                        d = 32'($urandom_range(0, 40));
                    if (a < MW && $urandom_range(0, 1) == 1)
                        c = mm[a];
                    else
                        c = 32'($urandom_range(0, 40));
                    set_req(i, op, a, d, c,
                            int'($urandom_range(0, 15)));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        idle();
        drain();

        // reset with two ops in flight
        send(0, 3, 9, 32'h55, 32'd0, 1);
        send(0, 3, 10, 32'h66, 32'd0, 2);
        idle();
        drain();
        send(0, 1, 9, 32'd1, 32'd0, 3);
        send(0, 1, 10, 32'd1, 32'd0, 4);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_resp_data", 64'(resp_data), 64'd0);
        chk("midrst_resp_success", 64'(resp_success), 64'd0);
        chk("midrst_resp_port", 64'(resp_port), 64'd0);
        chk("midrst_resp_id", 64'(resp_id), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        log_q.delete();
        send(0, 0, 9, 32'd0, 32'd0, 5);
        send(0, 0, 10, 32'd0, 32'd0, 6);
        idle();
        drain();
        chk_log("abort_9", 0, 32'h55, 1'b1);
        chk_log("abort_10", 1, 32'h66, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
